// File: rtl/oq_regs_rmw_file.sv
// oq_regs_rmw_file: per-output-queue counter RAM with a fetch-and-op datapath port and a host port.
// Two-stage pipeline (synchronous RAM read, then compute/write-back) with write-back forwarding.
module oq_regs_rmw_file #(
  parameter int REG_WIDTH         = 32,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int ADDR_WIDTH        = $clog2(NUM_OUTPUT_QUEUES),
  parameter int STARVE_LIMIT      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  init_done,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [1:0]            b_op,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [REG_WIDTH-1:0]  b_operand,
  output logic                  b_rvalid,
  output logic [REG_WIDTH-1:0]  b_rdata,
  output logic                  b_sat,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [REG_WIDTH-1:0]  a_wdata,
  output logic                  a_ack,
  output logic [REG_WIDTH-1:0]  a_rdata
);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_OUTPUT_QUEUES - 1);
  localparam logic [WAIT_W-1:0]     WAIT_MAX  = WAIT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_e;
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q;
  logic                  init_done_q;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  host_busy_q, host_busy_d;

  logic                  s1_valid_q, s1_host_q;
  logic [1:0]            s1_op_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [REG_WIDTH-1:0]  s1_operand_q;

  logic                  s2_valid_q;
  logic [ADDR_WIDTH-1:0] s2_addr_q;
  logic [REG_WIDTH-1:0]  s2_data_q;

  logic                  b_rvalid_q, b_sat_q, a_ack_q;
  logic [REG_WIDTH-1:0]  b_rdata_q, a_rdata_q;

  logic [REG_WIDTH-1:0]  mem [NUM_OUTPUT_QUEUES];
  logic [REG_WIDTH-1:0]  rd_q;

  logic                  run, host_pending, dp_accept, host_grant, acc_valid;
  logic [1:0]            acc_op;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [REG_WIDTH-1:0]  acc_operand;
  logic [REG_WIDTH-1:0]  old_val, new_val;
  logic [REG_WIDTH:0]    sum_w, diff_w;
  logic                  sat;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [REG_WIDTH-1:0]  mem_wdata;

  // A granted host request stays busy until its ack, so a held a_req is never granted twice.
  always_comb begin
    run          = (state_q == ST_RUN);
    host_pending = a_req && !host_busy_q;
    b_ready      = run && (wait_q != WAIT_MAX);
    dp_accept    = b_valid && b_ready;
    host_grant   = run && host_pending && !dp_accept;
    acc_valid    = dp_accept || host_grant;
    acc_op       = host_grant ? {1'b0, a_wr} : b_op;
    acc_addr     = host_grant ? a_addr : b_addr;
    acc_operand  = host_grant ? a_wdata : b_operand;

    wait_d = wait_q;
    if (host_grant || !run) begin
      wait_d = '0;
    end else if (host_pending && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + 1'b1;
    end

    host_busy_d = host_busy_q;
    if (host_grant) begin
      host_busy_d = 1'b1;
    end else if (a_ack_q) begin
      host_busy_d = 1'b0;
    end
  end

  // The RAM read for the op in stage 1 raced the previous op's write, so take stage 2 on a hit.
  always_comb begin
    old_val = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_data_q : rd_q;
    sum_w   = {1'b0, old_val} + {1'b0, s1_operand_q};
    diff_w  = {1'b0, old_val} - {1'b0, s1_operand_q};
    new_val = old_val;
    sat     = 1'b0;
    case (op_e'(s1_op_q))
      OP_READ:  new_val = old_val;
      OP_WRITE: new_val = s1_operand_q;
      OP_ADD: begin
        sat     = sum_w[REG_WIDTH];
        new_val = sum_w[REG_WIDTH] ? '1 : sum_w[REG_WIDTH-1:0];
      end
      OP_SUB: begin
        sat     = diff_w[REG_WIDTH];
        new_val = diff_w[REG_WIDTH] ? '0 : diff_w[REG_WIDTH-1:0];
      end
      default: new_val = old_val;
    endcase

    mem_we    = (state_q == ST_INIT) || s1_valid_q;
    mem_waddr = (state_q == ST_INIT) ? init_addr_q : s1_addr_q;
    mem_wdata = (state_q == ST_INIT) ? '0 : new_val;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_q <= mem[acc_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      init_done_q  <= 1'b0;
      init_addr_q  <= '0;
      wait_q       <= '0;
      host_busy_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_host_q    <= 1'b0;
      s1_op_q      <= '0;
      s1_addr_q    <= '0;
      s1_operand_q <= '0;
      s2_valid_q   <= 1'b0;
      s2_addr_q    <= '0;
      s2_data_q    <= '0;
      b_rvalid_q   <= 1'b0;
      b_rdata_q    <= '0;
      b_sat_q      <= 1'b0;
      a_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == LAST_ADDR) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase

      wait_q      <= wait_d;
      host_busy_q <= host_busy_d;

      s1_valid_q <= acc_valid;
      s1_host_q  <= host_grant;
      if (acc_valid) begin
        s1_op_q      <= acc_op;
        s1_addr_q    <= acc_addr;
        s1_operand_q <= acc_operand;
      end

      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_q <= s1_addr_q;
        s2_data_q <= new_val;
      end

      b_rvalid_q <= s1_valid_q && !s1_host_q;
      if (s1_valid_q && !s1_host_q) begin
        b_rdata_q <= old_val;
        b_sat_q   <= sat;
      end

      a_ack_q <= s1_valid_q && s1_host_q;
      if (s1_valid_q && s1_host_q) begin
        a_rdata_q <= old_val;
      end
    end
  end

  assign init_done = init_done_q;
  assign b_rvalid  = b_rvalid_q;
  assign b_rdata   = b_rdata_q;
  assign b_sat     = b_sat_q;
  assign a_ack     = a_ack_q;
  assign a_rdata   = a_rdata_q;

endmodule

// File: tb/tb_oq_regs_rmw_file.sv
// tb_oq_regs_rmw_file: table-driven vectors plus hand sequences; a negedge monitor
// queues expected results at acceptance/grant and compares them when rvalid/ack appear.
module tb_oq_regs_rmw_file;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          init_done;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [1:0]    b_op = '0;
  logic [AW-1:0] b_addr = '0;
  logic [W-1:0]  b_operand = '0;
  logic          b_rvalid;
  logic [W-1:0]  b_rdata;
  logic          b_sat;
  logic          a_req = 1'b0;
  logic          a_wr = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [W-1:0]  a_wdata = '0;
  logic          a_ack;
  logic [W-1:0]  a_rdata;

  oq_regs_rmw_file #(
    .REG_WIDTH(W), .NUM_OUTPUT_QUEUES(N), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .init_done(init_done),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_addr(b_addr), .b_operand(b_operand),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_sat(b_sat),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] rdata;
    logic         sat;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [W-1:0]  operand;
    logic [W-1:0]  expRdata;
    logic          expSat;
    int            idleBefore;
  } vec_t;

  exp_t         dpQ[$];
  exp_t         hostQ[$];
  vec_t         vecs[$];
  int           compared = 0;
  int           mismatched = 0;
  logic [W-1:0] curExpRdata = '0;
  logic         curExpSat = 1'b0;
  logic [W-1:0] hostExp = '0;
  bit           hostWaiting = 1'b0;
  int           reqCyc = 0;
  int           grantCyc = 0;
  int           ackCount = 0;
  int           lowReadyCnt = 0;

  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    end
  endfunction

  function automatic void addVec(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] operand,
                                 input logic [W-1:0] expRdata, input logic expSat, input int idleBefore);
    vec_t v;
    v.op = op; v.addr = addr; v.operand = operand;
    v.expRdata = expRdata; v.expSat = expSat; v.idleBefore = idleBefore;
    vecs.push_back(v);
  endfunction

  // Monitor: grant/accept decisions and result checks, all sampled at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        checkOutput("quiet during reset", {62'b0, b_rvalid, a_ack}, 64'd0);
        dpQ.delete();
        hostQ.delete();
        hostWaiting = 1'b0;
      end else begin
        if (b_rvalid) begin
          if (dpQ.size() == 0) begin
            checkOutput("spurious b_rvalid", b_rvalid, 64'd0);
          end else begin
            e = dpQ.pop_front();
            checkOutput("b_rdata", b_rdata, e.rdata);
            checkOutput("b_sat", b_sat, e.sat);
            checkOutput("b latency", cyc - e.cyc, 64'd2);
          end
        end
        if (a_ack) begin
          ackCount++;
          if (hostQ.size() == 0) begin
            checkOutput("spurious a_ack", a_ack, 64'd0);
          end else begin
            e = hostQ.pop_front();
            checkOutput("a_rdata", a_rdata, e.rdata);
            checkOutput("a latency", cyc - e.cyc, 64'd2);
          end
        end
        if (b_valid && b_ready) begin
          e.rdata = curExpRdata; e.sat = curExpSat; e.cyc = cyc;
          dpQ.push_back(e);
        end
        if (hostWaiting && a_req && init_done && (!b_valid || !b_ready)) begin
          e.rdata = hostExp; e.sat = 1'b0; e.cyc = cyc;
          hostQ.push_back(e);
          hostWaiting = 1'b0;
          grantCyc = cyc;
        end
        if (init_done && !b_ready) lowReadyCnt++;
      end
    end
  end

  // Datapath op: called just after a rising edge, returns just after the edge following acceptance.
  task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] operand,
                               input logic [W-1:0] expR, input logic expS);
    int budget = 0;
    b_valid = 1'b1; b_op = op; b_addr = addr; b_operand = operand;
    curExpRdata = expR; curExpSat = expS;
    @(negedge clk); #1;
    while (!b_ready && budget < 20) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!b_ready) checkOutput("b_ready timeout", b_ready, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic applyHostStimulus(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] wdata,
                                   input logic [W-1:0] expR);
    int startAck = ackCount;
    int budget = 0;
    a_wr = wr; a_addr = addr; a_wdata = wdata; hostExp = expR;
    a_req = 1'b1; hostWaiting = 1'b1; reqCyc = cyc;
    while (ackCount == startAck && budget < 50) begin
      @(negedge clk); #1;
      budget++;
    end
    if (ackCount == startAck) checkOutput("a_ack timeout", ackCount - startAck, 64'd1);
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      b_valid = 1'b0;
      repeat (n) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("ctrl outputs in reset", {59'b0, init_done, b_ready, b_rvalid, b_sat, a_ack}, 64'd0);
    checkOutput("b_rdata in reset", b_rdata, 64'd0);
    checkOutput("a_rdata in reset", a_rdata, 64'd0);
  endtask

  task automatic runInit();
    int   n = 0;
    logic readyEarly = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (init_done) break;
      if (b_ready) readyEarly = 1'b1;
    end
    checkOutput("init_done cycles", n, N);
    checkOutput("b_ready low during init", readyEarly, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lowBefore;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs();
    runInit();

    for (int a = 0; a < N; a++) addVec(2'd0, AW'(a), '0, '0, 1'b0, 0);
    addVec(2'd2, 3'd3, 32'd5, 32'd0,  1'b0, 0);
    addVec(2'd2, 3'd3, 32'd5, 32'd5,  1'b0, 0);
    addVec(2'd2, 3'd3, 32'd5, 32'd10, 1'b0, 0);
    addVec(2'd2, 3'd3, 32'd5, 32'd15, 1'b0, 0);
    addVec(2'd0, 3'd3, 32'd0, 32'd20, 1'b0, 0);
    addVec(2'd1, 3'd1, 32'hFFFF_FFF0, 32'd0, 1'b0, 0);
    addVec(2'd2, 3'd1, 32'h20, 32'hFFFF_FFF0, 1'b1, 0);
    addVec(2'd0, 3'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    addVec(2'd1, 3'd2, 32'd3, 32'd0, 1'b0, 0);
    addVec(2'd3, 3'd2, 32'd7, 32'd3, 1'b1, 0);
    addVec(2'd0, 3'd2, 32'd0, 32'd0, 1'b0, 0);
    addVec(2'd1, 3'd4, 32'hFFFF_FFFE, 32'd0, 1'b0, 0);
    addVec(2'd2, 3'd4, 32'd1, 32'hFFFF_FFFE, 1'b0, 0);
    addVec(2'd0, 3'd4, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    addVec(2'd3, 3'd3, 32'd20, 32'd20, 1'b0, 0);
    addVec(2'd0, 3'd3, 32'd0, 32'd0, 1'b0, 0);
    addVec(2'd1, 3'd5, 32'd100, 32'd0, 1'b0, 0);
    addVec(2'd2, 3'd5, 32'd1, 32'd100, 1'b0, 1);
    addVec(2'd0, 3'd5, 32'd0, 32'd101, 1'b0, 1);
    addVec(2'd1, 3'd5, 32'd200, 32'd101, 1'b0, 2);
    addVec(2'd0, 3'd5, 32'd0, 32'd200, 1'b0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      idle(vecs[i].idleBefore);
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].operand, vecs[i].expRdata, vecs[i].expSat);
    end
    idle(4);
    checkOutput("dp queue drained", dpQ.size(), 64'd0);

    // Host starved by a continuous datapath stream must win after STARVE_LIMIT losses.
    lowBefore = lowReadyCnt;
    fork
      begin
        for (int i = 0; i < 12; i++) applyStimulus(2'd0, 3'd7, '0, '0, 1'b0);
        b_valid = 1'b0;
      end
      begin
        @(posedge clk); #1;
        applyHostStimulus(1'b1, 3'd0, 32'hA5, 32'd0);
      end
    join
    checkOutput("host wait cycles", grantCyc - reqCyc, SL);
    checkOutput("b_ready low cycles", lowReadyCnt - lowBefore, 64'd1);
    applyStimulus(2'd0, 3'd0, '0, 32'hA5, 1'b0);
    idle(3);

    // Host write granted at t, datapath add to the same entry at t+1.
    fork
      applyHostStimulus(1'b1, 3'd6, 32'd7, 32'd0);
      begin
        @(posedge clk); #1;
        applyStimulus(2'd2, 3'd6, 32'd1, 32'd7, 1'b0);
        b_valid = 1'b0;
      end
    join
    checkOutput("host grant immediate", grantCyc - reqCyc, 64'd0);
    applyStimulus(2'd0, 3'd6, '0, 32'd8, 1'b0);
    b_valid = 1'b0;
    applyHostStimulus(1'b0, 3'd6, '0, 32'd8);
    idle(4);
    checkOutput("dp queue drained 2", dpQ.size(), 64'd0);
    checkOutput("host queue drained", hostQ.size(), 64'd0);

    // Reset with two ops accepted and not yet answered.
    b_valid = 1'b1; b_op = 2'd1; b_addr = 3'd2; b_operand = 32'h55;
    curExpRdata = 32'd0; curExpSat = 1'b0;
    @(posedge clk); #1;
    b_addr = 3'd5; b_operand = 32'h77; curExpRdata = 32'd200;
    @(negedge clk); #1;
    reset_n = 1'b0;
    b_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs();
    runInit();
    for (int a = 0; a < N; a++) applyStimulus(2'd0, AW'(a), '0, '0, 1'b0);
    idle(4);
    checkOutput("dp queue drained after reset", dpQ.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
